// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flagged synchronous FIFO.
package fifo_pkg;
  localparam int DATA_W_DEF     = 8;
  localparam int DEPTH_LOG2_DEF = 4;

  // Occupancy spans 0..DEPTH inclusive, so it needs one bit beyond the address.
  function automatic int lvl_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int AW     = 4
) (
  input  logic              Clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**AW];

  always_ff @(posedge Clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy, status flags and sticky error flags.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int FWFT       = 0
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  flush,
  input  logic                  wr_enable,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_enable,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic [DEPTH_LOG2:0]   afull_thresh,
  input  logic [DEPTH_LOG2:0]   aempty_thresh,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  half,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int LW    = lvl_w(DEPTH_LOG2);

  logic [LW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, ram_rdata;
  logic              rd_valid_q, rd_valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic              push_ok, pop_ok;

  assign level        = level_q;
  assign full         = (level_q == LW'(DEPTH));
  assign empty        = (level_q == '0);
  assign half         = (level_q >= LW'(DEPTH / 2));
  assign almost_full  = (level_q >= afull_thresh);
  assign almost_empty = (level_q <= aempty_thresh);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A pop frees the slot the push needs, so a full FIFO still accepts push+pop.
  assign pop_ok  = rd_enable & ~empty;
  assign push_ok = wr_enable & (~full | pop_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    // Set wins over clear.
    ovf_d      = (ovf_q & ~clr_err) | (wr_enable & ~push_ok);
    unf_d      = (unf_q & ~clr_err) | (rd_enable & empty);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + LW'(1);
      if (pop_ok) begin
        rd_ptr_d   = rd_ptr_q + LW'(1);
        rd_data_d  = ram_rdata;
        rd_valid_d = 1'b1;
      end
      if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
      else if (pop_ok && !push_ok) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  fifo_ram #(.DATA_W(DATA_W), .AW(DEPTH_LOG2)) u_ram (
    .Clk     (Clk),
    .we_i    (push_ok & ~flush & Reset_n),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o (ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = ram_rdata;
    assign rd_valid = ~empty;
  end else begin : g_reg
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: FWFT=0 and FWFT=1 instances share stimulus and a queue-based model.
module tb_sync_fifo_flags;
  logic       clk = 1'b0;
  logic       rst_n, flush, wr_en, rd_en, clr;
  logic [7:0] wr_d;
  logic [4:0] afull_t = 5'd12, aempty_t = 5'd3;

  logic [7:0] rdd0, rdd1;
  logic [4:0] lvl0, lvl1;
  logic rv0, rv1, fu0, fu1, em0, em1, af0, af1, ae0, ae1, hf0, hf1, ov0, ov1, un0, un1;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_W(8), .DEPTH_LOG2(4), .FWFT(0)) dut0 (
    .Clk(clk), .Reset_n(rst_n), .flush(flush), .wr_enable(wr_en), .wr_data(wr_d),
    .rd_enable(rd_en), .rd_data(rdd0), .rd_valid(rv0), .afull_thresh(afull_t),
    .aempty_thresh(aempty_t), .full(fu0), .empty(em0), .almost_full(af0),
    .almost_empty(ae0), .half(hf0), .level(lvl0), .overflow(ov0), .underflow(un0),
    .clr_err(clr));

  sync_fifo_flags #(.DATA_W(8), .DEPTH_LOG2(4), .FWFT(1)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .flush(flush), .wr_enable(wr_en), .wr_data(wr_d),
    .rd_enable(rd_en), .rd_data(rdd1), .rd_valid(rv1), .afull_thresh(afull_t),
    .aempty_thresh(aempty_t), .full(fu1), .empty(em1), .almost_full(af1),
    .almost_empty(ae1), .half(hf1), .level(lvl1), .overflow(ov1), .underflow(un1),
    .clr_err(clr));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: contents as a queue; the occupancy is simply its size.
  int   q[$];
  logic [7:0] m_rd = '0;
  bit   m_rv, m_ovf, m_unf, started;
  bit   m_emp, m_full, m_pop, m_push;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_rd = '0; m_rv = 0; m_ovf = 0; m_unf = 0;
      started = 1;
    end else begin
      m_emp  = (q.size() == 0);
      m_full = (q.size() == 16);
      m_pop  = rd_en && !m_emp;
      m_push = wr_en && (!m_full || m_pop);
      m_ovf  = (m_ovf && !clr) || (wr_en && !m_push);
      m_unf  = (m_unf && !clr) || (rd_en && m_emp);
      m_rv   = 0;
      if (flush) q.delete();
      else begin
        if (m_pop) begin m_rd = 8'(q.pop_front()); m_rv = 1; end
        if (m_push) q.push_back(int'(wr_d));
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      int n;
      n = q.size();
      chk("level0", lvl0, n);            chk("level1", lvl1, n);
      chk("full0", fu0, n == 16);        chk("full1", fu1, n == 16);
      chk("empty0", em0, n == 0);        chk("empty1", em1, n == 0);
      chk("half0", hf0, n >= 8);         chk("half1", hf1, n >= 8);
      chk("afull0", af0, n >= int'(afull_t));   chk("afull1", af1, n >= int'(afull_t));
      chk("aempty0", ae0, n <= int'(aempty_t)); chk("aempty1", ae1, n <= int'(aempty_t));
      chk("ovf0", ov0, m_ovf);           chk("ovf1", ov1, m_ovf);
      chk("unf0", un0, m_unf);           chk("unf1", un1, m_unf);
      chk("rvalid0", rv0, m_rv);         chk("rdata0", rdd0, m_rd);
      chk("rvalid1", rv1, n > 0);
      if (n > 0) chk("rdata1", rdd1, q[0]);
    end
  end

  task automatic cyc(input bit w, input logic [7:0] d, input bit r,
                     input bit fl = 0, input bit cl = 0);
    wr_en = w; wr_d = d; rd_en = r; flush = fl; clr = cl;
    @(negedge clk);
    wr_en = 0; rd_en = 0; flush = 0; clr = 0;
  endtask

  initial begin
    rst_n = 0; flush = 0; wr_en = 0; rd_en = 0; clr = 0; wr_d = '0;
    cyc(0, 0, 0); cyc(0, 0, 0);
    rst_n = 1;
    chk("rst_level", lvl0, 0);  chk("rst_empty", em0, 1); chk("rst_aempty", ae0, 1);
    chk("rst_full", fu0, 0);    chk("rst_half", hf0, 0);  chk("rst_afull", af0, 0);
    chk("rst_rvalid", rv0, 0);  chk("rst_rdata", rdd0, 0);
    chk("rst_ovf", ov0, 0);     chk("rst_unf", un0, 0);

    // Fill one word at a time, watching each threshold crossing.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0);
      case (i)
        0:  begin chk("fwft_first_valid", rv1, 1); chk("fwft_first_data", rdd1, 8'h00); end
        2:  chk("aempty_at3", ae0, 1);
        3:  chk("aempty_at4", ae0, 0);
        6:  chk("half_at7", hf0, 0);
        7:  chk("half_at8", hf0, 1);
        10: chk("afull_at11", af0, 0);
        11: chk("afull_at12", af0, 1);
        14: chk("full_at15", fu0, 0);
        15: chk("full_at16", fu0, 1);
        default: ;
      endcase
    end
    cyc(1, 8'h10, 0);
    chk("ovf_set", ov0, 1); chk("lvl_after_ovf", lvl0, 16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1);
      chk("pop_valid", rv0, 1); chk("pop_data", rdd0, 8'(i));
    end
    cyc(0, 0, 0);
    chk("idle_rvalid", rv0, 0); chk("drained_empty", em0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("ovf_clr", ov0, 0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0);
    cyc(1, 8'hAA, 1);
    chk("fullpp_level", lvl0, 16); chk("fullpp_ovf", ov0, 0); chk("fullpp_data", rdd0, 8'h20);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1);
    chk("last_pop_AA", rdd0, 8'hAA); chk("fullpp_empty", em0, 1);

    // Empty with simultaneous push and pop.
    cyc(1, 8'h55, 1);
    chk("emptypp_unf", un0, 1); chk("emptypp_level", lvl0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("unf_clr", un0, 0);
    cyc(0, 0, 1);
    chk("pop_55", rdd0, 8'h55); chk("pop_55_valid", rv0, 1);

    // First-word-fall-through ordering.
    cyc(1, 8'h11, 0);
    chk("fwft_11", rdd1, 8'h11); chk("fwft_11_valid", rv1, 1);
    cyc(1, 8'h22, 0);
    cyc(0, 0, 1);
    chk("fwft_22", rdd1, 8'h22); chk("reg_11", rdd0, 8'h11);
    cyc(0, 0, 1);
    chk("fwft_drained", rv1, 0);

    // Flush beats push; then reset mid-stream.
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h40 + i), 0);
    chk("level9", lvl0, 9);
    cyc(1, 8'hEE, 0, 1);
    chk("flush_level", lvl0, 0); chk("flush_empty", em0, 1); chk("flush_rvalid", rv0, 0);
    cyc(0, 0, 1);
    chk("unf_before_rst", un0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 0);
    cyc(0, 0, 1);
    rst_n = 0;
    cyc(1, 8'h77, 1, 1, 1);
    rst_n = 1;
    chk("rst2_level", lvl0, 0); chk("rst2_empty", em0, 1); chk("rst2_unf", un0, 0);
    chk("rst2_rvalid", rv0, 0); chk("rst2_rdata", rdd0, 0); chk("rst2_fwft_valid", rv1, 0);

    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
          $urandom_range(0, 60) == 0, $urandom_range(0, 30) == 0);
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 60) == 0, $urandom_range(0, 30) == 0);

    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, giving DEPTH = 2**DEPTH_LOG2 entries (legal range 2..10).
REQ-003 SHALL have parameter FWFT, default 0: 0 = registered read (1-cycle latency), 1 = first-word-fall-through.
REQ-004 SHALL have port list: Clk  in  1  single clock, all logic on rising edge (one clock; no other clocks).
REQ-005 Reset_n  in  1  synchronous active-low reset, sampled on rising Clk.
REQ-006 flush  in  1  synchronous empty request; memory contents are not cleared.
REQ-007 wr_enable  in  1  push request; wr_data  in  DATA_W  push data.
REQ-008 rd_enable  in  1  pop request; rd_data  out  DATA_W  read data; rd_valid  out  1  rd_data qualifier.
REQ-009 afull_thresh  in  DEPTH_LOG2+1  almost-full level; aempty_thresh  in  DEPTH_LOG2+1  almost-empty level.
REQ-010 full, empty, almost_full, almost_empty, half  out  1 each  status flags; level  out  DEPTH_LOG2+1  occupancy.
REQ-011 overflow, underflow  out  1 each  sticky error flags; clr_err  in  1  clears both sticky flags.

Function
REQ-012 Push accepted (push_ok) when wr_enable=1 and (full=0 or pop_ok=1); accepted data written at wr_ptr on the same edge.
REQ-013 Pop accepted (pop_ok) when rd_enable=1 and empty=0; a pop never uses data pushed in the same cycle.
REQ-014 wr_ptr, rd_ptr SHALL be DEPTH_LOG2+1 bits; the low bits address memory; the MSB is the wrap bit; both increment mod 2**(DEPTH_LOG2+1).
REQ-015 level SHALL be a register: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither; it never exceeds DEPTH and never goes below 0.
REQ-016 full = (level==DEPTH); empty = (level==0); half = (level>=DEPTH/2); almost_full = (level>=afull_thresh); almost_empty = (level<=aempty_thresh); all are decoded from the registered level.
REQ-017 Flag and level updates SHALL be visible in the cycle after the accepting edge.
REQ-018 FWFT=0: on pop_ok, rd_data SHALL be loaded with mem[rd_ptr] and rd_valid=1 in the next cycle; with no pop_ok, rd_valid=0 and rd_data holds its value.
REQ-019 FWFT=1: rd_data = mem[rd_ptr] (combinational read) and rd_valid = !empty; pop_ok advances to the next word.
REQ-020 Full with push and pop in the same cycle: both accepted; level stays DEPTH; overflow is not set.
REQ-021 Empty with push and pop in the same cycle: push accepted, pop rejected, underflow set, level becomes 1.
REQ-022 overflow SHALL set when wr_enable=1 and push is rejected; underflow SHALL set when rd_enable=1 and empty=1; both stay set until clr_err or reset.
REQ-023 When clr_err and a new error occur in the same cycle, the flag SHALL remain 1 (set wins).
REQ-024 flush SHALL take priority over push/pop: next cycle pointers=0, level=0, rd_valid=0; push/pop that cycle ignored; sticky flags unaffected.
REQ-025 Threshold inputs SHALL be usable quasi-statically; values above DEPTH make almost_full never assert.

Reset
REQ-026 On Reset_n=0 at a Clk edge: wr_ptr=0, rd_ptr=0, level=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-027 Reset SHALL give empty=1, almost_empty=1, full=0, half=0, almost_full=0 (for afull_thresh>0).
REQ-028 Reset mid-operation SHALL discard all stored words; memory array is not reset.
REQ-029 Reset SHALL take priority over flush, push, pop, and clr_err.

Structure
REQ-030 Package fifo_pkg SHALL hold the default constants (DATA_W_DEF=8, DEPTH_LOG2_DEF=4) and a function that computes level width.
REQ-031 Storage SHALL be a sub-module fifo_ram: DEPTH x DATA_W, one write port and one asynchronous read port, with no reset.
REQ-032 Pointer, level, flag, and error logic SHALL be in sync_fifo_flags; no gray coding or synchronisers (single clock).

Verification
REQ-033 Defaults, FWFT=0: push 16 words 0x00..0x0F, then 1 more -> full=1 after 16th, overflow=1, level=16; pop 16 -> data 0x00..0x0F, each 1 cycle after pop.
REQ-034 Full, push 0xAA + pop same cycle -> level stays 16, overflow=0; the last word popped is 0xAA.
REQ-035 Empty, push 0x55 + pop same cycle -> underflow=1, level=1; clr_err -> underflow=0; next pop returns 0x55.
REQ-036 afull_thresh=12, aempty_thresh=3: push 1 word at a time -> almost_empty drops at level 4, half rises at 8, almost_full rises at 12.
REQ-037 FWFT=1: push 0x11, 0x22 -> rd_data=0x11 with rd_valid=1 one cycle after push; pop -> rd_data=0x22.
REQ-038 With level=9, pulse flush together with push -> level=0, empty=1; pull Reset_n low mid-stream -> all outputs as REQ-026/027.
